// File: rtl/io_uart_in_pkg.sv
// -----------------------------------------------------------------------------
// io_uart_in_pkg
// Shared constants for the UART receive bus slave: default register word
// addresses, RX_STAT / RX_DATA bit positions and a helper that builds the
// RX_DATA word.
// -----------------------------------------------------------------------------
package io_uart_in_pkg;

  localparam logic [13:0] RX_DATA_ADR_DEF = 14'h3C02;
  localparam logic [13:0] RX_STAT_ADR_DEF = 14'h3C03;

  // RX_STAT bit positions.
  localparam int ST_NEMPTY  = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_IRQEN   = 8;
  localparam int ST_CNT_LSB = 16;

  // RX_DATA bit positions.
  localparam int DT_VALID   = 31;

  // RX_DATA word: valid flag on top, character in the low byte, zero when empty.
  function automatic logic [31:0] data_word(input logic valid, input logic [7:0] ch);
    logic [31:0] w;
    w = '0;
    if (valid) begin
      w[DT_VALID] = 1'b1;
      w[7:0]      = ch;
    end
    return w;
  endfunction

endpackage

// File: rtl/io_uart_in_fifo.sv
// -----------------------------------------------------------------------------
// io_uart_in_fifo
// Synchronous 8-bit FIFO, depth 2**FIFO_AW, first-word-fall-through head.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       write request and character
//   pop             read request (ignored while empty)
//   dout            head character (valid when !empty)
//   full, empty     registered-count based flags
//   count           number of stored entries (0 .. 2**FIFO_AW)
//   drop            push refused because the FIFO was full and not popping
// A push while full is accepted when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module io_uart_in_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [7:0]         din,
  input  logic               pop,
  output logic [7:0]         dout,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count,
  output logic               drop
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; pointers and count alone decide
  // which entries are valid, so the array maps onto plain RAM/flops without
  // a reset network.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_in.sv
// -----------------------------------------------------------------------------
// io_uart_in
// UART receive-side bus slave: buffers characters from the UART receive path
// in a small FIFO and exposes them to the CPU as two dma_io words.
//   RX_DATA_ADR : [31] valid, [7:0] head character (reading pops)
//   RX_STAT_ADR : [0] not_empty, [1] full, [2] overrun (W1C), [8] irq_en,
//                 [16+FIFO_AW:16] count
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   dma_io_we/wadr/wdata          bus write
//   dma_io_radr/radr_en           bus read request
//   dma_io_rdata_in/dma_io_rdata  read chain in / out (1-cycle latency)
//   uart_io_rx_char/rx_we         receive character strobe
//   uart_io_rx_full               back-pressure (FIFO full)
//   interrupt_rx                  level interrupt, data available
// Build option: IO_UART_IN_IRQ_EN adds the irq_en bit and drives
// interrupt_rx; without it interrupt_rx is tied low and RX_STAT[8] reads 0.
// -----------------------------------------------------------------------------
module io_uart_in
  import io_uart_in_pkg::*;
#(
  parameter int          FIFO_AW     = 4,
  parameter logic [13:0] RX_DATA_ADR = RX_DATA_ADR_DEF,
  parameter logic [13:0] RX_STAT_ADR = RX_STAT_ADR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_io_we,
  input  logic [15:2] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [15:2] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  input  logic [7:0]  uart_io_rx_char,
  input  logic        uart_io_rx_we,
  output logic        uart_io_rx_full,
  output logic        interrupt_rx
);

  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic [FIFO_AW:0] count;
  logic             drop;
  logic             rd_data_sel;
  logic             rd_stat_sel;
  logic             stat_wr;
  logic             overrun;
  logic             irq_en;
  logic             rd_hit;
  logic [31:0]      rd_data_q;
  logic [31:0]      rd_word;

  assign rd_data_sel = dma_io_radr_en && (dma_io_radr == RX_DATA_ADR);
  assign rd_stat_sel = dma_io_radr_en && (dma_io_radr == RX_STAT_ADR);
  assign stat_wr     = dma_io_we && (dma_io_wadr == RX_STAT_ADR);

  // The pop request is the raw data-register read; the FIFO ignores it when empty.
  io_uart_in_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (uart_io_rx_we),
    .din   (uart_io_rx_char),
    .pop   (rd_data_sel),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count),
    .drop  (drop)
  );

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    rd_word = '0;
    if (rd_data_sel) begin
      rd_word = data_word(!empty, head);
    end else if (rd_stat_sel) begin
      rd_word[ST_NEMPTY]                  = !empty;
      rd_word[ST_FULL]                    = full;
      rd_word[ST_OVR]                     = overrun;
      rd_word[ST_IRQEN]                   = irq_en;
      rd_word[ST_CNT_LSB +: FIFO_AW + 1]  = count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_hit    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_hit <= rd_data_sel || rd_stat_sel;
      if (rd_data_sel || rd_stat_sel) rd_data_q <= rd_word;
    end
  end

  // A fresh overrun in the same cycle as a write-1-to-clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (stat_wr && dma_io_wdata[ST_OVR]) begin
      overrun <= 1'b0;
    end
  end

`ifdef IO_UART_IN_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (stat_wr) irq_en <= dma_io_wdata[ST_IRQEN];
      irq_q <= irq_en && !empty;
    end
  end

  assign interrupt_rx = irq_q;
`else
  assign irq_en       = 1'b0;
  assign interrupt_rx = 1'b0;
`endif

  assign dma_io_rdata    = rd_hit ? rd_data_q : dma_io_rdata_in;
  assign uart_io_rx_full = full;

  // Only a few write-data bits are meaningful; fold the rest into a sink.
  logic unused_wdata;
  assign unused_wdata = ^dma_io_wdata;

endmodule

// File: doc/io_uart_in.md
Name: io_uart_in

Overview:
- Receive-direction companion to io_uart_out: the CPU reads UART input characters through the dma_io bus.
- Characters arrive from uart_top's receive path via a strobe interface and are buffered in a small synchronous FIFO.
- Data and status are exposed as two memory-mapped words; the block joins the dma_io_rdata read chain.

Parameters:
- FIFO_AW, 4, log2 of FIFO depth (depth = 16 entries of 8 bits).
- RX_DATA_ADR, 14'h3C02, dma_io word address of the RX data register.
- RX_STAT_ADR, 14'h3C03, dma_io word address of the RX status/control register.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- dma_io_we  in  1  bus write strobe.
- dma_io_wadr  in  14 ([15:2])  bus write word address.
- dma_io_wdata  in  32  bus write data.
- dma_io_radr  in  14 ([15:2])  bus read word address.
- dma_io_radr_en  in  1  bus read strobe.
- dma_io_rdata_in  in  32  read data from the downstream chain element.
- dma_io_rdata  out  32  read data toward the CPU.
- uart_io_rx_char  in  8  received character.
- uart_io_rx_we  in  1  one-cycle push strobe for uart_io_rx_char.
- uart_io_rx_full  out  1  FIFO full, back-pressure to the UART receive path.
- interrupt_rx  out  1  level interrupt, RX data available.

Behaviour:
- Single clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - FIFO empty, wr_ptr = rd_ptr = 0, count = 0.
  - overrun = 0, irq_en = 0.
  - rd_hit = 0, rd_data_q = 0.
  - uart_io_rx_full = 0, interrupt_rx = 0.
- FIFO:
  - count width is FIFO_AW+1; pointers wrap modulo 2^FIFO_AW.
  - empty = (count == 0); full = (count == 2^FIFO_AW).
  - uart_io_rx_full = full, taken from registered count, so it has no combinational path from uart_io_rx_we.
- Push (uart_io_rx_we = 1):
  - Not full: write the character at wr_ptr, increment wr_ptr.
  - Full: drop the character, set overrun sticky; FIFO contents unchanged.
- Pop: occurs when dma_io_radr_en = 1, dma_io_radr = RX_DATA_ADR, and the FIFO is not empty. Increment rd_ptr.
- Push and pop in the same cycle:
  - Not full and not empty: both act, count unchanged.
  - Full: the pop frees a slot and the push is accepted; no overrun.
  - Empty: the push is accepted; the pop sees empty and does nothing.
- Read timing, 1-cycle latency:
  - On a dma_io_radr_en cycle, register rd_hit (address is RX_DATA_ADR or RX_STAT_ADR) and rd_data_q (the selected word).
  - Next cycle: dma_io_rdata = rd_hit ? rd_data_q : dma_io_rdata_in (combinational pass-through).
  - rd_hit clears on any cycle without a hit.
- RX_DATA word:
  - [31] valid, [7:0] head character, other bits 0.
  - Read while empty returns 32'h0 and does not pop.
- RX_STAT word:
  - [0] not_empty, [1] full, [2] overrun, [8] irq_en.
  - [16+FIFO_AW:16] count; other bits 0.
- Writes:
  - dma_io_we with dma_io_wadr = RX_STAT_ADR: wdata[2] = 1 clears overrun (write-1-to-clear); wdata[8] loads irq_en.
  - If a clear and a new overrun happen in the same cycle, the set wins.
  - Writes to RX_DATA_ADR are ignored.
- interrupt_rx = irq_en & not_empty, registered (one cycle after the state change).
- Reset mid-operation: all state returns to reset values immediately; buffered characters are lost.

Optional Feature:
- Macro IO_UART_IN_IRQ_EN.
- Defined: irq_en register exists; interrupt_rx behaves as above; RX_STAT[8] reads irq_en.
- Undefined: no irq_en flop; interrupt_rx tied 0; RX_STAT[8] reads 0; wdata[8] ignored.

Decomposition:
- Shared package/header:
  - RX_DATA_ADR and RX_STAT_ADR defaults.
  - Status bit indices (ST_NEMPTY=0, ST_FULL=1, ST_OVR=2, ST_IRQEN=8, ST_CNT_LSB=16).
  - Data valid bit index (DT_VALID=31).
- One natural sub-module: io_uart_in_fifo, a parameterized synchronous FIFO (FIFO_AW, 8-bit) with push, pop, full, empty and count. The bus decode and registers stay in io_uart_in.

Test Plan:
1. Reset, then read RX_STAT -> 32'h0; read address 14'h0100 with dma_io_rdata_in = 32'hDEADBEEF -> dma_io_rdata = 32'hDEADBEEF the following cycle.
2. Push 0x41, 0x42, then read RX_DATA twice -> 32'h80000041, then 32'h80000042; a third read -> 32'h0; RX_STAT[0] = 0.
3. Push 17 characters 0x00..0x10 -> uart_io_rx_full = 1 after the 16th; RX_STAT = 32'h00100007 (count 16, overrun, full, not_empty); 16 reads return 0x00..0x0F; then write 32'h4 to RX_STAT -> overrun = 0.
4. With the FIFO full, pop and push 0x55 in the same cycle -> overrun stays 0, count stays 16; the last character read is 0x55.
5. With IO_UART_IN_IRQ_EN: write 32'h100, then push 0x30 -> interrupt_rx = 1 within 2 cycles; reading the character -> interrupt_rx = 0. Without the macro, interrupt_rx stays 0 throughout.
6. Assert rst_n low with 5 characters buffered -> count, flags and outputs return to 0 immediately; after release, RX_DATA reads 32'h0.
